// File: rtl/rcc_pclk_div_ctrl.sv
// APB/timer prescaler control: applies software prescaler/TIMPRE changes one at a time
// and holds each for a settle window. Optional done flag via RCC_PCLK_DIV_DONE_FLAG_EN.
module rcc_pclk_div_ctrl #(
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned CNT_W      = $clog2(SETTLE_CYC + 1)
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       ppre_wr,
  input  logic [2:0] ppre_wdata,
  input  logic       timpre_wr,
  input  logic       timpre_wdata,
`ifdef RCC_PCLK_DIV_DONE_FLAG_EN
  input  logic       done_clr,
  output logic       done_flag,
  output logic       done_irq,
`endif
  output logic [2:0] div_sel,
  output logic       timpre,
  output logic       busy,
  output logic [2:0] ppre_rdata,
  output logic       timpre_rdata
);

  typedef enum logic [1:0] {StIdle, StSettlePpre, StSettleTim} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       div_sel_q, div_sel_d;
  logic             timpre_q, timpre_d;
  logic [2:0]       pend_ppre_q, pend_ppre_d;
  logic             pend_ppre_v_q, pend_ppre_v_d;
  logic             pend_tim_q, pend_tim_d;
  logic             pend_tim_v_q, pend_tim_v_d;
  logic [2:0]       ppre_rdata_q, ppre_rdata_d;
  logic             timpre_rdata_q, timpre_rdata_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      div_sel_q      <= 3'b000;
      timpre_q       <= 1'b0;
      pend_ppre_q    <= 3'b000;
      pend_ppre_v_q  <= 1'b0;
      pend_tim_q     <= 1'b0;
      pend_tim_v_q   <= 1'b0;
      ppre_rdata_q   <= 3'b000;
      timpre_rdata_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_sel_q      <= div_sel_d;
      timpre_q       <= timpre_d;
      pend_ppre_q    <= pend_ppre_d;
      pend_ppre_v_q  <= pend_ppre_v_d;
      pend_tim_q     <= pend_tim_d;
      pend_tim_v_q   <= pend_tim_v_d;
      ppre_rdata_q   <= ppre_rdata_d;
      timpre_rdata_q <= timpre_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    div_sel_d      = div_sel_q;
    timpre_d       = timpre_q;
    pend_ppre_d    = pend_ppre_q;
    pend_ppre_v_d  = pend_ppre_v_q;
    pend_tim_d     = pend_tim_q;
    pend_tim_v_d   = pend_tim_v_q;
    ppre_rdata_d   = ppre_rdata_q;
    timpre_rdata_d = timpre_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (pend_ppre_v_q && (pend_ppre_q != div_sel_q)) begin
          div_sel_d     = pend_ppre_q;
          pend_ppre_v_d = 1'b0;
          cnt_d         = CNT_W'(SETTLE_CYC - 1);
          state_d       = StSettlePpre;
        end else begin
          // Pending prescaler equal to the driven code: drop without settling.
          pend_ppre_v_d = 1'b0;
          if (pend_tim_v_q && (pend_tim_q != timpre_q)) begin
            timpre_d     = pend_tim_q;
            pend_tim_v_d = 1'b0;
            cnt_d        = CNT_W'(SETTLE_CYC - 1);
            state_d      = StSettleTim;
          end else begin
            pend_tim_v_d = 1'b0;
          end
        end
      end
      StSettlePpre, StSettleTim: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Software writes are captured in every state and override any clear above.
    if (ppre_wr) begin
      pend_ppre_d   = ppre_wdata;
      pend_ppre_v_d = 1'b1;
      ppre_rdata_d  = ppre_wdata;
    end
    if (timpre_wr) begin
      pend_tim_d     = timpre_wdata;
      pend_tim_v_d   = 1'b1;
      timpre_rdata_d = timpre_wdata;
    end
  end

  assign div_sel      = div_sel_q;
  assign timpre       = timpre_q;
  assign ppre_rdata   = ppre_rdata_q;
  assign timpre_rdata = timpre_rdata_q;
  assign busy = (state_q != StIdle) |
                (pend_ppre_v_q & (pend_ppre_q != div_sel_q)) |
                (pend_tim_v_q & (pend_tim_q != timpre_q));

`ifdef RCC_PCLK_DIV_DONE_FLAG_EN
  logic busy_d;
  logic done_flag_q, done_flag_d;

  // Next-cycle busy lets the flag rise in the same cycle busy is first seen low.
  assign busy_d = (state_d != StIdle) |
                  (pend_ppre_v_d & (pend_ppre_d != div_sel_d)) |
                  (pend_tim_v_d & (pend_tim_d != timpre_d));

  always_comb begin
    done_flag_d = done_flag_q;
    if (busy && !busy_d) begin
      done_flag_d = 1'b1;
    end else if (done_clr) begin
      done_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      done_flag_q <= 1'b0;
    end else begin
      done_flag_q <= done_flag_d;
    end
  end

  assign done_flag = done_flag_q;
  assign done_irq  = done_flag_q;
`endif

endmodule

// File: tb/tb_rcc_pclk_div_ctrl.sv
// Directed self-checking bench for rcc_pclk_div_ctrl (SETTLE_CYC=64).
module tb_rcc_pclk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       ppre_wr = 1'b0;
  logic [2:0] ppre_wdata = 3'b000;
  logic       timpre_wr = 1'b0;
  logic       timpre_wdata = 1'b0;
  logic [2:0] div_sel;
  logic       timpre;
  logic       busy;
  logic [2:0] ppre_rdata;
  logic       timpre_rdata;
`ifdef RCC_PCLK_DIV_DONE_FLAG_EN
  logic       done_clr = 1'b0;
  logic       done_flag;
  logic       done_irq;
`endif

  int total = 0;
  int bad = 0;

  rcc_pclk_div_ctrl #(.SETTLE_CYC(64)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .ppre_wr      (ppre_wr),
    .ppre_wdata   (ppre_wdata),
    .timpre_wr    (timpre_wr),
    .timpre_wdata (timpre_wdata),
`ifdef RCC_PCLK_DIV_DONE_FLAG_EN
    .done_clr     (done_clr),
    .done_flag    (done_flag),
    .done_irq     (done_irq),
`endif
    .div_sel      (div_sel),
    .timpre       (timpre),
    .busy         (busy),
    .ppre_rdata   (ppre_rdata),
    .timpre_rdata (timpre_rdata)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards are sampled at the following one.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset held, then released with no writes.
    #1;
    chk("rst_div_sel", {29'd0, div_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      chk("idle_div_sel", {29'd0, div_sel}, 32'd0);
      chk("idle_timpre", {31'd0, timpre}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Equal-value write: dropped, busy never rises.
    ppre_wr = 1'b1; ppre_wdata = 3'b000;
    tick();
    ppre_wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("eq_busy", {31'd0, busy}, 32'd0);
      chk("eq_div_sel", {29'd0, div_sel}, 32'd0);
      tick();
    end

    // 000 -> 001 is a raw-code change even though both are /1.
    ppre_wr = 1'b1; ppre_wdata = 3'b001;
    tick();
    ppre_wr = 1'b0;
    chk("div1_busy_cap", {31'd0, busy}, 32'd1);
    tick();
    chk("div1_div_sel", {29'd0, div_sel}, 32'd1);
    chk("div1_busy_settle", {31'd0, busy}, 32'd1);
    wait_idle("div1_idle");

    // Write 101 at T, then 111 at T+10 which must wait for the window to end.
    ppre_wr = 1'b1; ppre_wdata = 3'b101;
    tick();
    ppre_wr = 1'b0;
    chk("p5_cap_div_sel", {29'd0, div_sel}, 32'd1);
    chk("p5_cap_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 70; k++) begin
      tick();
      chk("p5_div_sel", {29'd0, div_sel}, (k < 66) ? 32'd5 : 32'd7);
      chk("p5_busy", {31'd0, busy}, 32'd1);
      if (k == 9) begin
        ppre_wr = 1'b1; ppre_wdata = 3'b111;
      end
      if (k == 10) ppre_wr = 1'b0;
    end
    chk("p7_rdata", {29'd0, ppre_rdata}, 32'd7);
    wait_idle("p7_idle");

    // Simultaneous prescaler and TIMPRE writes: prescaler first, TIMPRE after one window.
    ppre_wr = 1'b1; ppre_wdata = 3'b110;
    timpre_wr = 1'b1; timpre_wdata = 1'b1;
    tick();
    ppre_wr = 1'b0; timpre_wr = 1'b0;
    chk("both_cap_busy", {31'd0, busy}, 32'd1);
    chk("both_tim_rdata", {31'd0, timpre_rdata}, 32'd1);
    for (int k = 1; k <= 135; k++) begin
      tick();
      chk("both_div_sel", {29'd0, div_sel}, 32'd6);
      chk("both_timpre", {31'd0, timpre}, (k >= 66) ? 32'd1 : 32'd0);
      chk("both_busy", {31'd0, busy}, (k < 130) ? 32'd1 : 32'd0);
    end

    // Reset mid prescaler settle with a TIMPRE change pending.
    ppre_wr = 1'b1; ppre_wdata = 3'b100;
    timpre_wr = 1'b1; timpre_wdata = 1'b0;
    tick();
    ppre_wr = 1'b0; timpre_wr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_div_sel", {29'd0, div_sel}, 32'd4);
    chk("mid_timpre", {31'd0, timpre}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_div_sel", {29'd0, div_sel}, 32'd0);
    chk("mrst_timpre", {31'd0, timpre}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rdata", {29'd0, ppre_rdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick();
      chk("post_div_sel", {29'd0, div_sel}, 32'd0);
      chk("post_timpre", {31'd0, timpre}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
    end

`ifdef RCC_PCLK_DIV_DONE_FLAG_EN
    // Single change: flag rises on the first cycle busy reads low.
    chk("done_rst", {31'd0, done_flag}, 32'd0);
    ppre_wr = 1'b1; ppre_wdata = 3'b101;
    tick();
    ppre_wr = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      chk("done_busy", {31'd0, busy}, (k < 65) ? 32'd1 : 32'd0);
      chk("done_flag", {31'd0, done_flag}, (k < 65) ? 32'd0 : 32'd1);
      chk("done_irq", {31'd0, done_irq}, (k < 65) ? 32'd0 : 32'd1);
    end
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    chk("done_cleared", {31'd0, done_flag}, 32'd0);

    // done_clr at the same edge as a new completion: set wins.
    ppre_wr = 1'b1; ppre_wdata = 3'b110;
    tick();
    ppre_wr = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 64) done_clr = 1'b1;
    end
    tick();
    done_clr = 1'b0;
    chk("done_set_wins_busy", {31'd0, busy}, 32'd0);
    chk("done_set_wins", {31'd0, done_flag}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
